o_feature_writeback: RTL and testbench

- Downstream stage of the CLP datapath.
- Consumes the per-cycle scaled_feature stream, requantises each value to 16-bit signed and packs 8 values per 128-bit word.
- Writes packed words to external feature memory at consecutive word addresses.
- Started by a store pulse from instruction_decode. Reports completion on store_done, which ORs into the fetch_done_wire group.

---
 rtl/o_feature_writeback_pkg.sv | 18 +
 rtl/o_feature_word_fifo.sv | 49 ++++
 rtl/o_feature_writeback.sv | 142 ++++++++++++++
 tb/tb_o_feature_writeback.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/o_feature_writeback_pkg.sv
// Shared definitions for the feature write-back stage.
//   state_t          : write-back FSM encoding
//   LANES            : requantised values packed per bus word
//   OUT_MAX/OUT_MIN  : saturation bounds of a 16-bit signed lane
package o_feature_writeback_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam int LANES   = 8;
  localparam int OUT_MAX = 32767;
  localparam int OUT_MIN = -32768;

endpackage

// File: rtl/o_feature_word_fifo.sv
// Packed-word FIFO between the lane packer and the external write port.
// Ports:
//   clk, rst           : clock, async active-high reset (flushes contents)
//   push, push_data    : enqueue request and word (ignored when full)
//   pop                : dequeue request (ignored when empty)
//   full, empty        : occupancy flags
//   head               : word at the read pointer
module o_feature_word_fifo #(
  parameter int WIDTH = 128,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  // One extra pointer bit distinguishes full from empty.
  logic [AW:0] wr_ptr, rd_ptr;
  logic        do_push, do_pop;

  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= push_data;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/o_feature_writeback.sv
// Feature write-back: requantises the scaled feature stream to 16-bit signed,
// packs LANES values per bus word and writes words to consecutive addresses.
// Ports:
//   clk, rst                         : clock, async active-high reset
//   store_enable                     : start pulse (ignored unless idle)
//   dst_addr, store_count, shift_amt : job parameters, sampled on start
//   feature_in, feature_valid        : input stream
//   feature_ready                    : input accepted this cycle when valid
//   o_data_bus_port, o_feature_addr  : write data / word address
//   o_feature_wr_en, o_wr_ready      : write request / memory accept
//   busy, store_done                 : job in progress / completion pulse
module o_feature_writeback
  import o_feature_writeback_pkg::*;
#(
  parameter int IN_WIDTH   = 24,
  parameter int OUT_WIDTH  = 16,
  parameter int BUS_WIDTH  = 128,
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  store_enable,
  input  logic [ADDR_WIDTH-1:0] dst_addr,
  input  logic [15:0]           store_count,
  input  logic [3:0]            shift_amt,
  input  logic [IN_WIDTH-1:0]   feature_in,
  input  logic                  feature_valid,
  output logic                  feature_ready,
  output logic [BUS_WIDTH-1:0]  o_data_bus_port,
  output logic [ADDR_WIDTH-1:0] o_feature_addr,
  output logic                  o_feature_wr_en,
  input  logic                  o_wr_ready,
  output logic                  busy,
  output logic                  store_done
);

  localparam int LW = $clog2(LANES);

  // Round-half-up arithmetic shift, then clamp to the signed lane range.
  // One guard bit keeps x plus the rounding constant from overflowing.
  function automatic logic [OUT_WIDTH-1:0] requant(input logic [IN_WIDTH-1:0] x,
                                                   input logic [3:0] sh);
    logic signed [IN_WIDTH:0] ext, rnd, r;
    ext = $signed({x[IN_WIDTH-1], x});
    rnd = (sh == 4'd0) ? '0 : $signed((IN_WIDTH+1)'(1) << (sh - 4'd1));
    r   = (ext + rnd) >>> sh;
    if (r > $signed((IN_WIDTH+1)'(OUT_MAX)))      return OUT_WIDTH'(OUT_MAX);
    else if (r < $signed((IN_WIDTH+1)'(OUT_MIN))) return OUT_WIDTH'(OUT_MIN);
    else                                          return r[OUT_WIDTH-1:0];
  endfunction

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [15:0]           count_q, words_packed, words_written;
  logic [3:0]            shift_q;
  logic [LW-1:0]         lane;
  logic [BUS_WIDTH-1:0]  pack_reg, push_word;
  logic                  start, accept, last_lane, push, wr_fire;
  logic                  fifo_full, fifo_empty;
  logic [BUS_WIDTH-1:0]  fifo_head;

  assign start     = (state == S_IDLE) && store_enable;
  assign last_lane = (lane == LW'(LANES - 1));
  assign accept    = feature_valid && feature_ready;
  assign push      = accept && last_lane;
  assign wr_fire   = o_feature_wr_en && o_wr_ready;

  // Current partial word with the incoming lane merged in; on the last lane
  // this is the complete word pushed to the FIFO in the same cycle.
  always_comb begin
    push_word = pack_reg;
    push_word[lane*OUT_WIDTH +: OUT_WIDTH] = requant(feature_in, shift_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (store_enable) state_nxt = (store_count == '0) ? S_DONE : S_RUN;
      S_RUN:   if (words_packed == count_q) state_nxt = S_DRAIN;
      S_DRAIN: if (words_written == count_q) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // A same-cycle pop does not lift the full stall on the last lane.
  always_comb begin
    busy            = (state != S_IDLE);
    store_done      = (state == S_DONE);
    feature_ready   = (state == S_RUN) && (words_packed < count_q) && !(last_lane && fifo_full);
    o_feature_wr_en = !fifo_empty && ((state == S_RUN) || (state == S_DRAIN));
    o_data_bus_port = fifo_head;
    o_feature_addr  = base_q + ADDR_WIDTH'(words_written);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base_q        <= '0;
      count_q       <= '0;
      shift_q       <= '0;
      lane          <= '0;
      pack_reg      <= '0;
      words_packed  <= '0;
      words_written <= '0;
    end else if (start) begin
      base_q        <= dst_addr;
      count_q       <= store_count;
      shift_q       <= shift_amt;
      lane          <= '0;
      words_packed  <= '0;
      words_written <= '0;
    end else begin
      if (accept) begin
        pack_reg <= push_word;
        lane     <= last_lane ? '0 : lane + 1'b1;
        if (last_lane) words_packed <= words_packed + 16'd1;
      end
      if (wr_fire) words_written <= words_written + 16'd1;
    end
  end

  o_feature_word_fifo #(
    .WIDTH (BUS_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_word),
    .pop       (wr_fire),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (fifo_head)
  );

endmodule

// File: tb/tb_o_feature_writeback.sv
module tb_o_feature_writeback;

  logic         clk = 1'b0;
  logic         rst;
  logic         store_enable;
  logic [15:0]  dst_addr;
  logic [15:0]  store_count;
  logic [3:0]   shift_amt;
  logic [23:0]  feature_in;
  logic         feature_valid;
  logic         feature_ready;
  logic [127:0] o_data_bus_port;
  logic [15:0]  o_feature_addr;
  logic         o_feature_wr_en;
  logic         o_wr_ready;
  logic         busy;
  logic         store_done;

  o_feature_writeback dut (
    .clk             (clk),
    .rst             (rst),
    .store_enable    (store_enable),
    .dst_addr        (dst_addr),
    .store_count     (store_count),
    .shift_amt       (shift_amt),
    .feature_in      (feature_in),
    .feature_valid   (feature_valid),
    .feature_ready   (feature_ready),
    .o_data_bus_port (o_data_bus_port),
    .o_feature_addr  (o_feature_addr),
    .o_feature_wr_en (o_feature_wr_en),
    .o_wr_ready      (o_wr_ready),
    .busy            (busy),
    .store_done      (store_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  int           in_q[$];
  logic [15:0]  exp_addr[$];
  logic [127:0] exp_data[$];
  int           wr_count = 0;
  int           done_count = 0;
  logic [127:0] last_data;
  logic [15:0]  last_addr;
  int           bp_mode = 1;   // 0: wr_ready low, 1: high, 2: random

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference requantisation: round half up, floor division, clamp.
  function automatic int quant(input int x, input int sh);
    longint n, d, r;
    n = longint'(x) + ((sh > 0) ? (longint'(1) << (sh - 1)) : 0);
    d = longint'(1) << sh;
    r = (n >= 0) ? n / d : -((-n + d - 1) / d);
    if (r > 32767)  r = 32767;
    if (r < -32768) r = -32768;
    return int'(r);
  endfunction

  function automatic int rand_feature();
    if ($urandom_range(0, 1) == 0) return int'($urandom_range(0, 16777215)) - 8388608;
    return int'($urandom_range(0, 8191)) - 4096;
  endfunction

  // Top up in_q with random features and queue the expected writes.
  task automatic prep(input logic [15:0] base, input int cnt, input int sh);
    logic [127:0] w;
    while (in_q.size() < cnt * 8) in_q.push_back(rand_feature());
    for (int i = 0; i < cnt; i++) begin
      w = '0;
      for (int k = 0; k < 8; k++) w[16*k +: 16] = 16'(quant(in_q[i*8 + k], sh));
      exp_addr.push_back(16'(base + i));
      exp_data.push_back(w);
    end
  endtask

  task automatic start(input logic [15:0] base, input int cnt, input int sh);
    store_enable = 1'b1;
    dst_addr     = base;
    store_count  = 16'(cnt);
    shift_amt    = 4'(sh);
    @(posedge clk); #1;
    store_enable = 1'b0;
  endtask

  task automatic feed(input int n);
    bit acc;
    int budget;
    for (int i = 0; i < n; i++) begin
      feature_in    = 24'(in_q[0]);
      feature_valid = ($urandom_range(0, 3) != 0);
      acc = 1'b0;
      budget = 200;
      while (!acc && budget > 0) begin
        @(negedge clk);
        acc = feature_valid && feature_ready;
        @(posedge clk); #1;
        if (!acc) feature_valid = ($urandom_range(0, 2) != 0);
        budget--;
      end
      if (!acc) begin
        chk("feed_timeout", acc, 1'b1);
        feature_valid = 1'b0;
        return;
      end
      void'(in_q.pop_front());
    end
    feature_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int d0 = done_count;
    int budget = 400;
    while (done_count == d0 && budget > 0) begin
      @(posedge clk); #1;
      budget--;
    end
    chk({tag, "_done_seen"}, (done_count != d0), 1'b1);
    chk({tag, "_exp_drained"}, exp_data.size(), 0);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // wr_ready driver
  initial begin
    o_wr_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (bp_mode)
        0:       o_wr_ready = 1'b0;
        1:       o_wr_ready = 1'b1;
        default: o_wr_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Write-port monitor and scoreboard
  initial begin
    logic         prev_stall = 1'b0;
    logic [127:0] prev_data;
    logic [15:0]  prev_addr;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall && o_feature_wr_en) begin
          chk("stall_data_stable", o_data_bus_port, prev_data);
          chk("stall_addr_stable", o_feature_addr, prev_addr);
        end
        if (o_feature_wr_en && o_wr_ready) begin
          wr_count++;
          last_data = o_data_bus_port;
          last_addr = o_feature_addr;
          if (exp_data.size() == 0) begin
            chk("unexpected_write", o_feature_wr_en, 1'b0);
          end else begin
            chk("wr_data", o_data_bus_port, exp_data.pop_front());
            chk("wr_addr", o_feature_addr, exp_addr.pop_front());
          end
        end
        if (store_done) begin
          done_count++;
          chk("done_after_writes", exp_data.size(), 0);
        end
        prev_stall = o_feature_wr_en && !o_wr_ready;
        prev_data  = o_data_bus_port;
        prev_addr  = o_feature_addr;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ready"}, feature_ready, 1'b0);
    chk({tag, "_data"}, o_data_bus_port, 128'h0);
    chk({tag, "_addr"}, o_feature_addr, 16'h0);
    chk({tag, "_wr_en"}, o_feature_wr_en, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_done"}, store_done, 1'b0);
  endtask

  initial begin
    int w0, d0, sh;
    rst = 1'b1;
    store_enable = 1'b0;
    dst_addr = '0;
    store_count = '0;
    shift_amt = '0;
    feature_in = '0;
    feature_valid = 1'b0;
    idle(3);
    @(negedge clk);
    chk_all_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    idle(2);

    // Basic word, no shift
    bp_mode = 1;
    for (int i = 1; i <= 8; i++) in_q.push_back(i);
    prep(16'h0010, 1, 0);
    w0 = wr_count;
    start(16'h0010, 1, 0);
    @(negedge clk);
    chk("t1_busy", busy, 1'b1);
    @(posedge clk); #1;
    feed(8);
    wait_done("t1");
    chk("t1_writes", wr_count - w0, 1);
    chk("t1_word", last_data, 128'h0008_0007_0006_0005_0004_0003_0002_0001);
    chk("t1_addr", last_addr, 16'h0010);

    // Rounding and saturation
    in_q.push_back(24);
    in_q.push_back(-24);
    in_q.push_back(8388607);
    in_q.push_back(-8388608);
    prep(16'h0100, 1, 4);
    start(16'h0100, 1, 4);
    feed(8);
    wait_done("t2");
    chk("t2_lanes", last_data[63:0], 64'h8000_7FFF_FFFF_0002);

    // Backpressure: FIFO fills and input stalls
    bp_mode = 0;
    sh = int'($urandom_range(0, 15));
    prep(16'h2000, 6, sh);
    w0 = wr_count;
    start(16'h2000, 6, sh);
    feed(39);
    feature_in = 24'(in_q[0]);
    feature_valid = 1'b1;
    idle(3);
    @(negedge clk);
    chk("t3_stall_ready", feature_ready, 1'b0);
    chk("t3_stall_wr_en", o_feature_wr_en, 1'b1);
    chk("t3_no_writes", wr_count - w0, 0);
    @(posedge clk); #1;
    bp_mode = 1;
    feed(9);
    wait_done("t3");
    chk("t3_writes", wr_count - w0, 6);

    // Address wrap with random backpressure
    bp_mode = 2;
    sh = int'($urandom_range(0, 15));
    prep(16'hFFFE, 3, sh);
    start(16'hFFFE, 3, sh);
    feed(24);
    wait_done("t4");
    chk("t4_last_addr", last_addr, 16'h0000);
    bp_mode = 1;

    // Zero-count store
    w0 = wr_count;
    start(16'h3000, 0, 0);
    @(negedge clk);
    chk("t5_busy", busy, 1'b1);
    chk("t5_done", store_done, 1'b1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t5_busy_after", busy, 1'b0);
    chk("t5_done_after", store_done, 1'b0);
    chk("t5_no_writes", wr_count - w0, 0);
    @(posedge clk); #1;

    // Second start while running is ignored
    w0 = wr_count;
    prep(16'h0200, 2, 2);
    start(16'h0200, 2, 2);
    feed(3);
    store_enable = 1'b1;
    dst_addr = 16'h0300;
    store_count = 16'd5;
    shift_amt = 4'd0;
    @(posedge clk); #1;
    store_enable = 1'b0;
    feed(13);
    wait_done("t6");
    chk("t6_writes", wr_count - w0, 2);
    idle(2);
    @(negedge clk);
    chk("t6_idle", busy, 1'b0);
    @(posedge clk); #1;

    // Reset while draining with two queued words
    bp_mode = 0;
    prep(16'h0400, 2, 1);
    start(16'h0400, 2, 1);
    feed(16);
    idle(2);
    @(negedge clk);
    chk("t7_drain_busy", busy, 1'b1);
    chk("t7_drain_wr_en", o_feature_wr_en, 1'b1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk_all_zero("t7_reset");
    exp_data.delete();
    exp_addr.delete();
    w0 = wr_count;
    d0 = done_count;
    @(posedge clk); #1;
    rst = 1'b0;
    bp_mode = 1;
    idle(10);
    chk("t7_no_writes", wr_count - w0, 0);
    chk("t7_no_done", done_count - d0, 0);

    prep(16'h0500, 1, 3);
    start(16'h0500, 1, 3);
    feed(8);
    wait_done("t8");
    chk("t8_writes", wr_count - w0, 1);
    chk("t8_addr", last_addr, 16'h0500);

    idle(3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
